// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use/redirect stalls and flushes,
// and a data-memory wait FSM with timeout watchdog. Optional perf counters via HAZARD_PERF_CNT_EN.
module hazard_unit #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addrD,
    input  logic [REG_ADDR_W-1:0] i_rs2_addrD,
    input  logic [REG_ADDR_W-1:0] i_rs1_addrE,
    input  logic [REG_ADDR_W-1:0] i_rs2_addrE,
    input  logic [REG_ADDR_W-1:0] i_rd_addrE,
    input  logic [2:0]            i_result_srcE,
    input  logic                  i_pc_srcE,
    input  logic                  i_reg_weM,
    input  logic [REG_ADDR_W-1:0] i_rd_addrM,
    input  logic                  i_reg_weW,
    input  logic [REG_ADDR_W-1:0] i_rd_addrW,
    input  logic                  i_mem_stall,
    output logic                  o_stallF,
    output logic                  o_stallD,
    output logic                  o_stallE,
    output logic                  o_stallM,
    output logic                  o_stallW,
    output logic                  o_flushD,
    output logic                  o_flushE,
    output logic [1:0]            o_forward_a,
    output logic [1:0]            o_forward_b,
    output logic                  o_mem_timeout,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_t;

    state_t            state, state_next;
    logic [WCNT_W-1:0] wcnt, wcnt_next;
    logic              load_use;
    logic              run_rules;

    // Operand forwarding: Memory stage has priority over Writeback; x0 never forwards.
    always_comb begin
        o_forward_a = 2'b00;
        o_forward_b = 2'b00;
        if (i_reg_weM && (i_rd_addrM != '0) && (i_rd_addrM == i_rs1_addrE))
            o_forward_a = 2'b10;
        else if (i_reg_weW && (i_rd_addrW != '0) && (i_rd_addrW == i_rs1_addrE))
            o_forward_a = 2'b01;
        if (i_reg_weM && (i_rd_addrM != '0) && (i_rd_addrM == i_rs2_addrE))
            o_forward_b = 2'b10;
        else if (i_reg_weW && (i_rd_addrW != '0) && (i_rd_addrW == i_rs2_addrE))
            o_forward_b = 2'b01;
    end

    assign load_use = (i_result_srcE == 3'b001) && (i_rd_addrE != '0) &&
                      ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_next;
            wcnt  <= wcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        run_rules  = 1'b0;
        o_stallF   = 1'b0;
        o_stallD   = 1'b0;
        o_stallE   = 1'b0;
        o_stallM   = 1'b0;
        o_stallW   = 1'b0;
        o_flushD   = 1'b0;
        o_flushE   = 1'b0;

        case (state)
            RUN: run_rules = 1'b1;
            MEM_WAIT: begin
                if (!i_mem_stall) begin
                    run_rules  = 1'b1;
                    state_next = RUN;
                    wcnt_next  = '0;
                end else begin
                    {o_stallF, o_stallD, o_stallE, o_stallM, o_stallW} = 5'b11111;
                    if (wcnt == WCNT_W'(MEM_TIMEOUT))
                        state_next = TIMEOUT;
                    else
                        wcnt_next = wcnt + WCNT_W'(1);
                end
            end
            TIMEOUT: {o_stallF, o_stallD, o_stallE, o_stallM, o_stallW} = 5'b11111;
            default: state_next = RUN;
        endcase

        // Run-mode priority: memory stall, then redirect, then load-use bubble.
        if (run_rules) begin
            if (i_mem_stall) begin
                {o_stallF, o_stallD, o_stallE, o_stallM, o_stallW} = 5'b11111;
                state_next = MEM_WAIT;
                wcnt_next  = WCNT_W'(1);
            end else if (i_pc_srcE) begin
                o_flushD = 1'b1;
                o_flushE = 1'b1;
            end else if (load_use) begin
                o_stallF = 1'b1;
                o_stallD = 1'b1;
                o_flushE = 1'b1;
            end
        end
    end

    assign o_mem_timeout = (state == TIMEOUT);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (o_stallF) stall_cnt <= stall_cnt + CNT_W'(1);
            if (o_flushE) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt;
    assign o_flush_cnt = flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (MEM_TIMEOUT=4): driver queues hand-computed
// expectations each cycle, a negedge monitor pops and compares.
module tb_hazard_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [AW-1:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
    logic [2:0]    rsrc = '0;
    logic          pc = 1'b0, weM = 1'b0, weW = 1'b0, ms = 1'b0;
    logic          stallF, stallD, stallE, stallM, stallW, flushD, flushE, tmo;
    logic [1:0]    fa, fb;
    logic [CW-1:0] scnt, fcnt;

    // Operand values latched into the DUT by the next cyc() call
    logic [AW-1:0] v_rs1D = '0, v_rs2D = '0, v_rs1E = '0, v_rs2E = '0, v_rdE = '0, v_rdM = '0, v_rdW = '0;
    logic [2:0]    v_rsrc = '0;
    logic          v_weM = 1'b0, v_weW = 1'b0;

    typedef struct {
        string      name;
        logic [4:0] stl;
        logic [1:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       to;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [CW-1:0] sum_s = '0, sum_f = '0;

    hazard_unit #(.MEM_TIMEOUT(4), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .i_clk(clk), .i_arst(arst),
        .i_rs1_addrD(rs1D), .i_rs2_addrD(rs2D),
        .i_rs1_addrE(rs1E), .i_rs2_addrE(rs2E), .i_rd_addrE(rdE),
        .i_result_srcE(rsrc), .i_pc_srcE(pc),
        .i_reg_weM(weM), .i_rd_addrM(rdM), .i_reg_weW(weW), .i_rd_addrW(rdW),
        .i_mem_stall(ms),
        .o_stallF(stallF), .o_stallD(stallD), .o_stallE(stallE), .o_stallM(stallM), .o_stallW(stallW),
        .o_flushD(flushD), .o_flushE(flushE),
        .o_forward_a(fa), .o_forward_b(fb),
        .o_mem_timeout(tmo), .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
    );

    always #5 clk = ~clk;

    task automatic set_lu(input logic [2:0] s, input logic [AW-1:0] d, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        v_rsrc = s; v_rdE = d; v_rs1D = a1; v_rs2D = a2;
    endtask

    task automatic set_fw(input logic m_we, input logic [AW-1:0] m_rd, input logic w_we, input logic [AW-1:0] w_rd,
                          input logic [AW-1:0] e1, input logic [AW-1:0] e2);
        v_weM = m_we; v_rdM = m_rd; v_weW = w_we; v_rdW = w_rd; v_rs1E = e1; v_rs2E = e2;
    endtask

    // One clock cycle: apply inputs after the edge and queue the expected outputs.
    // stl = {F,D,E,M,W}, fl = {D,E}
    task automatic cyc(input string name, input logic r, input logic m, input logic p,
                       input logic [4:0] stl, input logic [1:0] fl,
                       input logic [1:0] efa, input logic [1:0] efb, input logic eto);
        exp_t e;
        @(posedge clk);
        #1;
        arst = r; ms = m; pc = p;
        rs1D = v_rs1D; rs2D = v_rs2D; rs1E = v_rs1E; rs2E = v_rs2E;
        rdE = v_rdE; rdM = v_rdM; rdW = v_rdW; rsrc = v_rsrc; weM = v_weM; weW = v_weW;
        if (r) begin
            sum_s = '0;
            sum_f = '0;
        end
        e.name = name; e.stl = stl; e.fl = fl; e.fa = efa; e.fb = efb; e.to = eto;
`ifdef HAZARD_PERF_CNT_EN
        e.sc = sum_s; e.fc = sum_f;
`else
        e.sc = '0; e.fc = '0;
`endif
        sb.push_back(e);
        if (!r) begin
            sum_s = sum_s + CW'(stl[4]);
            sum_f = sum_f + CW'(fl[0]);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] got_stl;
            e = sb.pop_front();
            got_stl = {stallF, stallD, stallE, stallM, stallW};
            n_checks++;
            if (got_stl !== e.stl || {flushD, flushE} !== e.fl || fa !== e.fa || fb !== e.fb || tmo !== e.to) begin
                n_fail++;
                $display("FAIL %s: got stall=%b flush=%b fwd_a=%b fwd_b=%b timeout=%b, expected stall=%b flush=%b fwd_a=%b fwd_b=%b timeout=%b",
                         e.name, got_stl, {flushD, flushE}, fa, fb, tmo, e.stl, e.fl, e.fa, e.fb, e.to);
            end
            n_checks++;
            if (scnt !== e.sc || fcnt !== e.fc) begin
                n_fail++;
                $display("FAIL %s_cnt: got stall_cnt=%0d flush_cnt=%0d, expected %0d %0d",
                         e.name, scnt, fcnt, e.sc, e.fc);
            end
        end
    end

    initial begin
        int guard;
        //  name            rst ms pc  stl       fl     fa     fb     to
        cyc("reset",        1, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        cyc("idle",         0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        set_lu(3'b001, 5, 0, 5);
        cyc("load_use",     0, 0, 0, 5'b11000, 2'b01, 2'b00, 2'b00, 0);
        set_lu(3'b000, 0, 0, 5);
        cyc("after_bubble", 0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        set_fw(1, 7, 1, 7, 7, 3);
        cyc("fwd_a_mem",    0, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b00, 0);
        set_fw(1, 0, 1, 7, 7, 3);
        cyc("fwd_a_wb",     0, 0, 0, 5'b00000, 2'b00, 2'b01, 2'b00, 0);
        set_fw(1, 7, 1, 7, 0, 3);
        cyc("fwd_a_x0",     0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        set_fw(1, 4, 1, 9, 4, 9);
        cyc("fwd_b_wb",     0, 0, 0, 5'b00000, 2'b00, 2'b10, 2'b01, 0);
        set_fw(0, 7, 0, 7, 7, 7);
        cyc("fwd_no_we",    0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        set_fw(0, 0, 0, 0, 0, 0);
        set_lu(3'b001, 5, 5, 0);
        cyc("redirect_lu",  0, 0, 1, 5'b00000, 2'b11, 2'b00, 2'b00, 0);
        set_lu(3'b001, 0, 0, 0);
        cyc("lu_x0",        0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        set_lu(3'b010, 5, 5, 0);
        cyc("not_load",     0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        set_lu(3'b000, 0, 0, 0);
        cyc("mw_1",         0, 1, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        cyc("mw_2",         0, 1, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        cyc("mw_3",         0, 1, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        cyc("mw_exit_redir",0, 0, 1, 5'b00000, 2'b11, 2'b00, 2'b00, 0);
        cyc("idle2",        0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        cyc("mw_lu_1",      0, 1, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        set_lu(3'b001, 6, 6, 0);
        cyc("mw_lu_wait",   0, 1, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        cyc("mw_exit_lu",   0, 0, 0, 5'b11000, 2'b01, 2'b00, 2'b00, 0);
        set_lu(3'b000, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            cyc($sformatf("to_wait_%0d", i), 0, 1, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        cyc("to_entered",   0, 1, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 1);
        cyc("to_sticky_pc", 0, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 1);
        cyc("to_sticky",    0, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 1);
        cyc("to_reset",     1, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        cyc("post_reset",   0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        cyc("mw_a",         0, 1, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        cyc("mw_b",         0, 1, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
        cyc("mw_reset",     1, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        // Counter scenario from a clean reset: one bubble plus one redirect
        cyc("cnt_idle",     0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);
        set_lu(3'b001, 5, 0, 5);
        cyc("cnt_lu",       0, 0, 0, 5'b11000, 2'b01, 2'b00, 2'b00, 0);
        set_lu(3'b000, 0, 0, 0);
        cyc("cnt_redirect", 0, 0, 1, 5'b00000, 2'b11, 2'b00, 2'b00, 0);
        cyc("cnt_final",    0, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0);

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
